// File: rtl/dfd_cla_pkg.sv
// Shared types and default widths for the CLA change-rate monitor.
// Holds the FSM state encoding used by the monitor and its counters.
package dfd_cla_pkg;

    localparam int CNT_WIDTH_DEF = 8;
    localparam int WIN_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/dfd_cr_csr_pkg.sv
// CSR view of the change-rate monitor control fields.
// One packed record carrying enable, threshold, window and holdoff.
package dfd_cr_csr_pkg;

    import dfd_cla_pkg::*;

    typedef struct packed {
        logic                     Enable;
        logic [CNT_WIDTH_DEF-1:0] Threshold;
        logic [WIN_WIDTH_DEF-1:0] WindowLen;
        logic [WIN_WIDTH_DEF-1:0] HoldoffLen;
    } ChangerateCsr_s;

endpackage

// File: rtl/dfd_cla_sat_counter.sv
// Loadable down-counter that stops at zero, with a zero flag.
// Ports: clock, reset, clr, load/load_value, dec -> value, zero.
module dfd_cla_sat_counter
    import dfd_cla_pkg::*;
#(
    parameter int WIDTH = WIN_WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    assign zero = (value == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && !zero) begin
            value <= value - WIDTH'(1);
        end
    end

endmodule

// File: rtl/dfd_cla_change_rate_monitor.sv
// Rate qualifier for CLA change pulses: counts changes per window,
// fires a one-cycle rate_match at threshold, then holds off.
// Ports: clock, reset, enable, clear, window_len, threshold,
// holdoff_len, change_match -> rate_match, change_count,
// window_active, saturated.
module dfd_cla_change_rate_monitor
    import dfd_cla_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int WIN_WIDTH = WIN_WIDTH_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [WIN_WIDTH-1:0] window_len,
    input  logic [CNT_WIDTH-1:0] threshold,
    input  logic [WIN_WIDTH-1:0] holdoff_len,
    input  logic                 change_match,
    output logic                 rate_match,
    output logic [CNT_WIDTH-1:0] change_count,
    output logic                 window_active,
    output logic                 saturated
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [1:0]           state;
    logic [1:0]           state_n;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_n;
    logic                 sat;
    logic                 sat_n;

    logic                 flush;
    logic                 live;
    logic [CNT_WIDTH:0]   sum;
    logic                 hit;
    logic [WIN_WIDTH-1:0] win_reload;

    logic                 win_load;
    logic                 win_dec;
    logic                 win_zero;
    logic [WIN_WIDTH-1:0] win_value;
    logic                 hold_load;
    logic                 hold_dec;
    logic                 hold_zero;
    logic [WIN_WIDTH-1:0] hold_value;

    assign flush = clear | ~enable;

    // The pulse cycle after a match is dead: changes are dropped
    // and the window is frozen, so pulses can never be adjacent.
    assign live = (state == ST_COUNT) && !rate_match;

    // Match is judged on the unsaturated sum, so a saturated
    // counter still compares correctly against the threshold.
    assign sum = {1'b0, cnt} + {{CNT_WIDTH{1'b0}}, change_match};
    assign hit = live && (threshold != '0)
              && (sum >= {1'b0, threshold});

    // A zero window length behaves as a one-cycle window.
    assign win_reload = (window_len == '0) ? '0
                      : window_len - WIN_WIDTH'(1);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sat_n     = sat;
        win_load  = 1'b0;
        win_dec   = 1'b0;
        hold_load = 1'b0;
        hold_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                state_n  = ST_COUNT;
                cnt_n    = '0;
                win_load = 1'b1;
            end
            ST_COUNT: begin
                if (hit) begin
                    cnt_n = '0;
                    if (holdoff_len == '0) begin
                        win_load = 1'b1;
                    end else begin
                        state_n   = ST_HOLD;
                        hold_load = 1'b1;
                    end
                end else if (live && win_zero) begin
                    cnt_n    = '0;
                    win_load = 1'b1;
                end else if (live) begin
                    win_dec = 1'b1;
                    if (sum >= {1'b0, CNT_MAX}) begin
                        cnt_n = CNT_MAX;
                        sat_n = 1'b1;
                    end else begin
                        cnt_n = sum[CNT_WIDTH-1:0];
                    end
                end
            end
            ST_HOLD: begin
                cnt_n = '0;
                if (hold_zero) begin
                    state_n  = ST_COUNT;
                    win_load = 1'b1;
                end else begin
                    hold_dec = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sat        <= 1'b0;
            rate_match <= 1'b0;
        end else if (flush) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sat        <= 1'b0;
            rate_match <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sat        <= sat_n;
            rate_match <= hit;
        end
    end

    dfd_cla_sat_counter #(.WIDTH(WIN_WIDTH)) u_win (
        .clock      (clock),
        .reset      (reset),
        .clr        (flush),
        .load       (win_load),
        .load_value (win_reload),
        .dec        (win_dec),
        .value      (win_value),
        .zero       (win_zero)
    );

    dfd_cla_sat_counter #(.WIDTH(WIN_WIDTH)) u_hold (
        .clock      (clock),
        .reset      (reset),
        .clr        (flush),
        .load       (hold_load),
        .load_value (holdoff_len),
        .dec        (hold_dec),
        .value      (hold_value),
        .zero       (hold_zero)
    );

    assign change_count  = cnt;
    assign window_active = (state == ST_COUNT);
    assign saturated     = sat;

endmodule

// File: tb/tb_dfd_cla_change_rate_monitor.sv
// Scoreboard bench for the CLA change-rate monitor.
// Expected outputs come from a cycle-level behavioural model.
module tb_dfd_cla_change_rate_monitor;

    import dfd_cla_pkg::*;
    import dfd_cr_csr_pkg::*;

    localparam int CW   = CNT_WIDTH_DEF;
    localparam int WW   = WIN_WIDTH_DEF;
    localparam int MAXC = (1 << CW) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_COUNT = 1;
    localparam int M_HOLD  = 2;

    typedef struct {
        bit rm;
        int cnt;
        bit act;
        bit sat;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           clear = 1'b0;
    logic           change_match = 1'b0;
    ChangerateCsr_s csr;
    logic           rate_match;
    logic [CW-1:0]  change_count;
    logic           window_active;
    logic           saturated;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    int m_mode  = M_IDLE;
    int m_cnt   = 0;
    int m_pos   = 0;
    int m_wlen  = 1;
    int m_hlen  = 0;
    int m_hcyc  = 0;
    bit m_pulse = 0;
    bit m_sat   = 0;

    always #5 clock = ~clock;

    dfd_cla_change_rate_monitor #(.CNT_WIDTH(CW), .WIN_WIDTH(WW)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (csr.Enable),
        .clear         (clear),
        .window_len    (csr.WindowLen),
        .threshold     (csr.Threshold),
        .holdoff_len   (csr.HoldoffLen),
        .change_match  (change_match),
        .rate_match    (rate_match),
        .change_count  (change_count),
        .window_active (window_active),
        .saturated     (saturated)
    );

    task automatic start_window();
        m_pos  = 0;
        m_wlen = (csr.WindowLen == 0) ? 1 : int'(csr.WindowLen);
    endtask

    // One clock of the reference behaviour, from the rules:
    // window position counts up to its length, a match starts a
    // dead pulse cycle followed by holdoff_len hold cycles.
    task automatic model(input bit rst, input bit clr, input bit chg);
        bit old_pulse;
        int total;
        int thr;
        old_pulse = m_pulse;
        m_pulse   = 0;
        thr       = int'(csr.Threshold);
        if (rst || clr || !csr.Enable) begin
            m_mode = M_IDLE;
            m_cnt  = 0;
            m_sat  = 0;
            m_pos  = 0;
            m_hcyc = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_COUNT;
            m_cnt  = 0;
            start_window();
        end else if (m_mode == M_COUNT) begin
            if (!old_pulse) begin
                total = m_cnt + int'(chg);
                if (thr != 0 && total >= thr) begin
                    m_pulse = 1;
                    m_cnt   = 0;
                    if (csr.HoldoffLen == 0) begin
                        start_window();
                    end else begin
                        m_mode = M_HOLD;
                        m_hlen = int'(csr.HoldoffLen);
                        m_hcyc = 0;
                    end
                end else if (m_pos == m_wlen - 1) begin
                    m_cnt = 0;
                    start_window();
                end else begin
                    m_cnt = (total > MAXC) ? MAXC : total;
                    m_pos++;
                    if (m_cnt == MAXC) m_sat = 1;
                end
            end
        end else begin
            m_hcyc++;
            if (m_hcyc > m_hlen) begin
                m_mode = M_COUNT;
                m_cnt  = 0;
                start_window();
            end
        end
    endtask

    // Called at a falling edge: drive, predict, queue, advance.
    task automatic step(input bit rst, input bit clr, input bit chg);
        exp_t e;
        reset        = rst;
        clear        = clr;
        change_match = chg;
        model(rst, clr, chg);
        e.rm  = m_pulse;
        e.cnt = m_cnt;
        e.act = (m_mode == M_COUNT);
        e.sat = m_sat;
        sb.push_back(e);
        @(negedge clock);
    endtask

    task automatic run(input int n, input bit chg);
        for (int i = 0; i < n; i++) step(0, 0, chg);
    endtask

    task automatic restart();
        step(0, 1, 0);
        step(0, 0, 0);
    endtask

    // Monitor: every rising edge the DUT presents a new output set.
    initial begin : monitor
        exp_t e;
        bit   prev_rm;
        prev_rm = 0;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                vectors++;
                if (rate_match !== e.rm
                    || int'(change_count) != e.cnt
                    || window_active !== e.act
                    || saturated !== e.sat) begin
                    miscompares++;
                    $display("FAIL vec%0d outputs rm/cnt/act/sat got %0b/%0d/%0b/%0b expected %0b/%0d/%0b/%0b",
                             vectors, rate_match, change_count,
                             window_active, saturated,
                             e.rm, e.cnt, e.act, e.sat);
                end
                if (rate_match === 1'b1 && prev_rm) begin
                    miscompares++;
                    $display("FAIL vec%0d back_to_back rate_match got 1 expected 0",
                             vectors);
                end
                prev_rm = (rate_match === 1'b1);
            end
        end
    end

    initial begin : stim
        int p;
        csr = '{Enable: 1'b1, Threshold: 8'd3,
                WindowLen: 16'd10, HoldoffLen: 16'd0};
        @(negedge clock);

        for (int i = 0; i < 3; i++) step(1, 0, 0);

        // window 10, threshold 3: changes on cycles 1, 4, 7
        step(0, 0, 0);
        for (int i = 0; i < 14; i++)
            step(0, 0, (i == 1 || i == 4 || i == 7));

        // reset while counting with count 3
        csr.Threshold = 8'd0;
        run(3, 1);
        step(1, 0, 0);
        run(2, 0);

        // window 4, threshold 3: changes straddle a boundary
        csr.Threshold = 8'd3;
        csr.WindowLen = 16'd4;
        restart();
        for (int i = 0; i < 10; i++)
            step(0, 0, (i == 1 || i == 2 || i == 4));

        // window 5, threshold 2: second change on last cycle
        csr.Threshold = 8'd2;
        csr.WindowLen = 16'd5;
        restart();
        for (int i = 0; i < 10; i++)
            step(0, 0, (i == 0 || i == 4));

        // holdoff 6, threshold 1, continuous changes
        csr.Threshold  = 8'd1;
        csr.WindowLen  = 16'd10;
        csr.HoldoffLen = 16'd6;
        restart();
        run(40, 1);

        // holdoff 0, threshold 1, continuous changes
        csr.HoldoffLen = 16'd0;
        restart();
        run(20, 1);

        // threshold 0, saturation then soft clear
        csr.Threshold = 8'd0;
        csr.WindowLen = 16'd1000;
        restart();
        run(300, 1);
        step(0, 1, 0);
        run(3, 0);

        // enable drop
        csr.Enable = 1'b0;
        run(3, 1);
        csr.Enable = 1'b1;

        // randomized blocks with live CSR changes
        for (int b = 0; b < 60; b++) begin
            csr.Threshold  = 8'($urandom_range(0, 4));
            csr.WindowLen  = 16'($urandom_range(0, 8));
            csr.HoldoffLen = 16'($urandom_range(0, 5));
            csr.Enable     = ($urandom_range(0, 9) != 0);
            p = $urandom_range(10, 95);
            for (int i = 0; i < 50; i++) begin
                if ($urandom_range(0, 24) == 0)
                    csr.Threshold = 8'($urandom_range(0, 4));
                if ($urandom_range(0, 24) == 0)
                    csr.WindowLen = 16'($urandom_range(0, 8));
                if ($urandom_range(0, 49) == 0)
                    csr.Enable = ~csr.Enable;
                step($urandom_range(0, 299) == 0,
                     $urandom_range(0, 99) == 0,
                     $urandom_range(0, 99) < p);
            end
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++)
            @(negedge clock);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending got %0d expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
